// File: rtl/imm_encoder.sv
// RISC-V immediate packer (inverse of imm_gen) with valid/ready input and output FIFO.
// Optional range check and saturating error counter enabled by defining IMM_RANGE_CHECK_EN.

// Generic synchronous FIFO, DEPTH a power of two.
// Latency: a push into an empty FIFO is visible at the head on the next cycle.
// Backpressure: o_push_rdy is low while full, from registered count only.
module imm_encoder_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push_vld,
    output logic         o_push_rdy,
    input  logic [W-1:0] i_push_dat,
    output logic         o_pop_vld,
    input  logic         i_pop_rdy,
    output logic [W-1:0] o_pop_dat
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_push_rdy = (r_count != FULL_CNT);
    assign o_pop_vld  = (r_count != '0);
    assign w_push     = i_push_vld & o_push_rdy;
    assign w_pop      = o_pop_vld & i_pop_rdy;
    // Head reads as zero when empty so the output is clean after reset.
    assign o_pop_dat  = o_pop_vld ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// Packs imm into the immediate field of base_instr for the selected format.
// Latency: 1 cycle from accept to out_valid when the FIFO is empty; full throughput.
// Backpressure: in_ready drops while the output FIFO is full.
module imm_encoder #(
    parameter int DEPTH     = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          base_instr,
    input  logic [2:0]           imm_src,
    input  logic [31:0]          imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          instr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_S = 3'b001;
    localparam logic [2:0] SRC_B = 3'b010;
    localparam logic [2:0] SRC_U = 3'b011;
    localparam logic [2:0] SRC_J = 3'b100;

    logic [31:0] w_packed;
    logic        w_err;
    logic        w_push;
    logic [32:0] w_head;

    always_comb begin
        w_packed = base_instr;
        case (imm_src)
            SRC_I: w_packed[31:20] = imm[11:0];
            SRC_S: begin
                w_packed[31:25] = imm[11:5];
                w_packed[11:7]  = imm[4:0];
            end
            SRC_B: begin
                w_packed[31]    = imm[12];
                w_packed[7]     = imm[11];
                w_packed[30:25] = imm[10:5];
                w_packed[11:8]  = imm[4:1];
            end
            SRC_U: w_packed[31:12] = imm[19:0];
            SRC_J: begin
                w_packed[31]    = imm[20];
                w_packed[19:12] = imm[19:12];
                w_packed[20]    = imm[11];
                w_packed[30:21] = imm[10:1];
            end
            default: w_packed = base_instr;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic [ERR_CNT_W-1:0] r_err_count;

    // Signed formats must be a sign extension of the encodable width.
    always_comb begin
        w_err = 1'b0;
        case (imm_src)
            SRC_I, SRC_S: w_err = !((&imm[31:11]) || !(|imm[31:11]));
            SRC_B:        w_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            SRC_J:        w_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            SRC_U:        w_err = |imm[31:20];
            default:      w_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_push && w_err && !(&r_err_count)) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`else
    logic w_unused_imm;

    assign w_err        = 1'b0;
    assign err_count    = '0;
    assign w_unused_imm = ^imm[31:21];
`endif

    assign w_push = in_valid & in_ready;

    imm_encoder_fifo #(
        .W     (33),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push_vld (in_valid),
        .o_push_rdy (in_ready),
        .i_push_dat ({w_err, w_packed}),
        .o_pop_vld  (out_valid),
        .i_pop_rdy  (out_ready),
        .o_pop_dat  (w_head)
    );

    assign instr   = w_head[31:0];
    assign out_err = w_head[32];
endmodule
